// File: rtl/alu_cmd_sequencer.sv
// Command buffer and issue controller in front of a combinational ALU.
// Commands {sel, a, b} are queued in a small circular FIFO. One command at a
// time is popped into registered ALU operands. The ALU result is then latched
// into a result register that has its own valid/ready handshake.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_sel,
  input  logic [W-1:0]           cmd_a,
  input  logic [W-1:0]           cmd_b,
  output logic [3:0]             alu_sel,
  output logic [W-1:0]           alu_a,
  output logic [W-1:0]           alu_b,
  input  logic [W-1:0]           alu_x,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [W-1:0]           res_data,
  output logic [3:0]             res_sel,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      sel_mem [DEPTH];
  logic [W-1:0]    a_mem   [DEPTH];
  logic [W-1:0]    b_mem   [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic [3:0]      alu_sel_reg, res_sel_reg;
  logic [W-1:0]    alu_a_reg, alu_b_reg, res_data_reg;
  logic            push, pop, capture;

  // Ready is forced low during reset so nothing is accepted at the reset edge.
  assign cmd_ready = (count_reg < FULL) & ~reset;
  assign push      = cmd_valid & cmd_ready;

  // FIFO storage: each entry loads only when the write pointer addresses it.
  // Contents need no reset; the pointers and count define what is valid.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == AW'(gi))) begin
        sel_mem[gi] <= cmd_sel;
        a_mem[gi]   <= cmd_a;
        b_mem[gi]   <= cmd_b;
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  // Count tracks occupancy; a push and a pop in the same cycle cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Issue FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic. Pop reads the registered count, so a command pushed
  // into an empty FIFO is first seen by the FSM in the cycle after the push.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        capture    = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          if (count_reg != '0) begin
            pop        = 1'b1;
            state_next = ISSUE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand registers change only on a pop and otherwise hold the last command.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_sel_reg <= '0;
      alu_a_reg   <= '0;
      alu_b_reg   <= '0;
    end else if (pop) begin
      alu_sel_reg <= sel_mem[rd_ptr_reg];
      alu_a_reg   <= a_mem[rd_ptr_reg];
      alu_b_reg   <= b_mem[rd_ptr_reg];
    end
  end

  // The result register loads once per issue. It stays stable through HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_data_reg <= '0;
      res_sel_reg  <= '0;
    end else if (capture) begin
      res_data_reg <= alu_x;
      res_sel_reg  <= alu_sel_reg;
    end
  end

  // A result is valid exactly while the FSM waits in HOLD for the consumer.
  assign res_valid = (state_reg == HOLD);
  assign busy      = (state_reg != IDLE) || (count_reg != '0);
  assign count     = count_reg;
  assign alu_sel   = alu_sel_reg;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign res_data  = res_data_reg;
  assign res_sel   = res_sel_reg;

endmodule
